// File: rtl/conv3x3_stage.sv
// Valid-mode 3x3 convolution stage: streams a ROW_SIZE x ROW_SIZE image from a BRAM and writes
// shifted, ReLU'd, saturated results row-major. Optional bias add is enabled by CONV_BIAS_EN.
module conv3x3_stage #(
  parameter int ADDR_WIDTH   = 7,
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ROW_SIZE     = 8,
  parameter int SHIFT        = 0,
  parameter int ACC_WIDTH    = DATA_WIDTH + WEIGHT_WIDTH + 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [9*WEIGHT_WIDTH-1:0]     weights,
`ifdef CONV_BIAS_EN
  input  logic signed [ACC_WIDTH-1:0]   bias,
`endif
  output logic                          busy,
  output logic                          done,
  output logic [ADDR_WIDTH-1:0]         rd_addr,
  input  logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          wr_en,
  output logic [ADDR_WIDTH-1:0]         wr_addr,
  output logic [DATA_WIDTH-1:0]         wr_data
);

  localparam int OUT_DIM    = ROW_SIZE - 2;
  localparam int PROD_WIDTH = DATA_WIDTH + 1 + WEIGHT_WIDTH;

  typedef enum logic [1:0] {IDLE, FETCH, LAST, FINISH} state_t;

  state_t                         state, state_next;
  logic [3:0]                     k;
  logic [ADDR_WIDTH-1:0]          out_row, out_col;
  logic signed [WEIGHT_WIDTH-1:0] w_q [9];
  logic signed [ACC_WIDTH-1:0]    acc;
  logic signed [ACC_WIDTH-1:0]    bias_term;

  logic [3:0]                     tap_sel;
  logic signed [WEIGHT_WIDTH-1:0] tap_w;
  logic signed [DATA_WIDTH:0]     pix_s;
  logic signed [PROD_WIDTH-1:0]   product;
  logic signed [ACC_WIDTH-1:0]    prod_ext, acc_sum, pre_shift, shifted;
  logic [DATA_WIDTH-1:0]          pixel;
  logic [ADDR_WIDTH-1:0]          wr_addr_next;
  logic                           last_pixel;
  int                             base_pix, tap_off;

`ifdef CONV_BIAS_EN
  logic signed [ACC_WIDTH-1:0]    bias_q;
  assign bias_term = bias_q;
`else
  assign bias_term = '0;
`endif

  assign busy = (state == FETCH) || (state == LAST);
  assign done = (state == FINISH);

  // Read address is combinational so the BRAM's registered read lands one tap later
  always_comb begin
    base_pix = int'(out_row) * ROW_SIZE + int'(out_col);
    tap_off  = (int'(k) / 3) * ROW_SIZE + int'(k) % 3;
    rd_addr  = '0;
    if (state == FETCH) rd_addr = ADDR_WIDTH'(base_pix + tap_off);
  end

  // Data arriving now belongs to the tap issued last cycle; LAST consumes tap 8
  always_comb begin
    tap_sel = 4'd0;
    if (state == LAST)  tap_sel = 4'd8;
    else if (k != 4'd0) tap_sel = k - 4'd1;
    tap_w     = w_q[tap_sel];
    pix_s     = {1'b0, rd_data};
    product   = pix_s * tap_w;
    prod_ext  = {{(ACC_WIDTH-PROD_WIDTH){product[PROD_WIDTH-1]}}, product};
    acc_sum   = acc + prod_ext;
    pre_shift = acc_sum + bias_term;
    shifted   = pre_shift >>> SHIFT;
    pixel     = shifted[DATA_WIDTH-1:0];
    if (shifted[ACC_WIDTH-1])                      pixel = '0;
    else if (|shifted[ACC_WIDTH-2:DATA_WIDTH])     pixel = '1;
    wr_addr_next = ADDR_WIDTH'(int'(out_row) * OUT_DIM + int'(out_col));
    last_pixel   = (out_row == ADDR_WIDTH'(OUT_DIM-1)) && (out_col == ADDR_WIDTH'(OUT_DIM-1));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = FETCH;
      FETCH:   if (k == 4'd8) state_next = LAST;
      LAST:    state_next = last_pixel ? FINISH : FETCH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      k       <= '0;
      out_row <= '0;
      out_col <= '0;
      acc     <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      for (int i = 0; i < 9; i++) w_q[i] <= '0;
`ifdef CONV_BIAS_EN
      bias_q  <= '0;
`endif
    end else begin
      state <= state_next;
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < 9; i++) w_q[i] <= weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
`ifdef CONV_BIAS_EN
            bias_q <= bias;
`endif
            out_row <= '0;
            out_col <= '0;
            acc     <= '0;
            k       <= '0;
          end
        end
        FETCH: begin
          if (k != 4'd0) acc <= acc_sum;
          k <= (k == 4'd8) ? 4'd0 : k + 4'd1;
        end
        LAST: begin
          wr_data <= pixel;
          wr_addr <= wr_addr_next;
          wr_en   <= 1'b1;
          acc     <= '0;
          if (out_col == ADDR_WIDTH'(OUT_DIM-1)) begin
            out_col <= '0;
            out_row <= out_row + 1'b1;
          end else begin
            out_col <= out_col + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv3x3_stage.sv
// Bench for conv3x3_stage: two instances (SHIFT=0 and SHIFT=3) share one image and are
// checked write-by-write against a direct arithmetic model of the 3x3 convolution.
module tb_conv3x3_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [71:0] w_bus = '0;
  logic        busy0, done0, wr_en0, busy1, done1, wr_en1;
  logic [6:0]  rd_addr0, wr_addr0, rd_addr1, wr_addr1;
  logic [7:0]  rd_data0, wr_data0, rd_data1, wr_data1;
`ifdef CONV_BIAS_EN
  logic signed [20:0] bias_v = '0;
`endif

  bit [7:0] img [64];
  int w_m [9];
  int bias_m = 0;
  int out0 [36];
  int out1 [36];
  int wr_idx0 = 0, wr_idx1 = 0, done_cnt = 0;
  int n_checks = 0, n_pass = 0;

  always #5 clk = ~clk;

  conv3x3_stage #(.SHIFT(0)) dut (
    .clk(clk), .rst(rst), .start(start), .weights(w_bus),
`ifdef CONV_BIAS_EN
    .bias(bias_v),
`endif
    .busy(busy0), .done(done0), .rd_addr(rd_addr0), .rd_data(rd_data0),
    .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0));

  conv3x3_stage #(.SHIFT(3)) dut_s3 (
    .clk(clk), .rst(rst), .start(start), .weights(w_bus),
`ifdef CONV_BIAS_EN
    .bias(bias_v),
`endif
    .busy(busy1), .done(done1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1));

  // Input BRAMs with one-cycle registered read
  always @(posedge clk) begin
    rd_data0 <= img[rd_addr0[5:0]];
    rd_data1 <= img[rd_addr1[5:0]];
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int model_pixel(input int idx, input int sh);
    int r, c, acc;
    r = idx / 6;
    c = idx % 6;
    acc = bias_m;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        acc += int'(img[(r+i)*8 + c + j]) * w_m[3*i + j];
    acc = acc >>> sh;
    if (acc < 0) acc = 0;
    if (acc > 255) acc = 255;
    return acc;
  endfunction

  // Every write must be the next row-major pixel and match the model
  always @(negedge clk) begin
    if (!rst) begin
      if (done0) done_cnt++;
      if (wr_en0) begin
        if (wr_idx0 > 35) check("write overflow s0", wr_idx0, 35);
        else begin
          check("wr_addr s0", int'(wr_addr0), wr_idx0);
          check("wr_data s0", int'(wr_data0), model_pixel(wr_idx0, 0));
          out0[wr_idx0] = int'(wr_data0);
        end
        wr_idx0++;
      end
      if (wr_en1) begin
        if (wr_idx1 > 35) check("write overflow s3", wr_idx1, 35);
        else begin
          check("wr_addr s3", int'(wr_addr1), wr_idx1);
          check("wr_data s3", int'(wr_data1), model_pixel(wr_idx1, 3));
          out1[wr_idx1] = int'(wr_data1);
        end
        wr_idx1++;
      end
    end
  end

  task automatic load_kernel(input int fill, input int center);
    for (int i = 0; i < 9; i++) w_m[i] = (i == 4) ? center : fill;
    for (int i = 0; i < 9; i++) w_bus[i*8 +: 8] = 8'(w_m[i]);
  endtask

  task automatic load_image(input int ramp, input int val);
    for (int i = 0; i < 64; i++) img[i] = ramp ? 8'(i) : 8'(val);
  endtask

  // Runs one frame; disrupt_at>0 re-pulses start and scrambles the weight bus mid-frame
  task automatic run_frame(input int disrupt_at);
    int lat;
    bit seen;
    wr_idx0 = 0; wr_idx1 = 0; done_cnt = 0; seen = 0;
    @(negedge clk);
    start = 1'b1;
    lat = 1;
    for (int n = 0; n < 1000 && !seen; n++) begin
      @(posedge clk);
      lat++;
      #1;
      if (lat == 2) begin
        start = 1'b0;
        check("busy after start", int'(busy0), 1);
      end
      if (disrupt_at > 0 && lat == disrupt_at) begin
        start = 1'b1;
        w_bus = '0;
      end
      if (disrupt_at > 0 && lat == disrupt_at + 1) start = 1'b0;
      if (done0) seen = 1;
    end
    check("done latency", lat, 362);
    check("done s3 aligned", int'(done1), 1);
    @(posedge clk);
    #1;
    check("done one cycle", int'(done0), 0);
    check("write count s0", wr_idx0, 36);
    check("write count s3", wr_idx1, 36);
    check("done pulses", done_cnt, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", int'(busy0), 0);
    check("reset done", int'(done0), 0);
    check("reset wr_en", int'(wr_en0), 0);
    check("reset rd_addr", int'(rd_addr0), 0);
    check("reset wr_addr", int'(wr_addr0), 0);
    check("reset wr_data", int'(wr_data0), 0);
    @(negedge clk);
    rst = 1'b0;

    // Identity kernel on the ramp image
    load_kernel(0, 1);
    load_image(1, 0);
    run_frame(0);
    check("identity out[0]", out0[0], 9);
    check("identity out[35]", out0[35], 54);
    check("identity s3 out[35]", out1[35], 6);

    // Saturation
    load_kernel(1, 1);
    load_image(0, 255);
    run_frame(0);
    check("saturate out[17]", out0[17], 255);
    check("saturate s3 out[17]", out1[17], 255);

    // ReLU clamp
    load_kernel(-1, -1);
    load_image(1, 0);
    run_frame(0);
    check("relu out[10]", out0[10], 0);

    // Shift
    load_kernel(1, 1);
    load_image(0, 8);
    run_frame(0);
    check("sum out[20]", out0[20], 72);
    check("shift3 out[20]", out1[20], 9);
`ifdef CONV_BIAS_EN
    bias_m = -72;
    bias_v = -72;
    run_frame(0);
    check("bias s3 out[20]", out1[20], 0);
    check("bias s0 out[20]", out0[20], 0);
    bias_m = 0;
    bias_v = '0;
`endif

    // Reset mid-frame at cycle 100
    load_kernel(0, 1);
    load_image(1, 0);
    wr_idx0 = 0; wr_idx1 = 0; done_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (98) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort busy", int'(busy0), 0);
    check("abort wr_en", int'(wr_en0), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (400) @(posedge clk);
    #1;
    check("abort done pulses", done_cnt, 0);
    check("abort writes", wr_idx0, 9);
    run_frame(0);
    check("post-abort out[35]", out0[35], 54);

    // Start while busy plus weight change mid-frame
    run_frame(50);
    check("busy-start out[0]", out0[0], 9);
    repeat (30) @(posedge clk);
    #1;
    check("no second frame", int'(busy0), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
